seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Sequential unsigned restoring divider. It is the inverse-operation companion to the lab's shift-add multiplier processor.
- Same front-panel style: the dividend is loaded from SW, the divisor is taken from SW when Run is pressed, and the quotient and remainder are exposed on Aval/Bval for the board's hex display logic.
- Sits at the top-level beside the HEX drivers. Run and Load arrive already debounced and synchronized.

Parameters:
- N, 8, operand width in bits (dividend, divisor, quotient, remainder).

Ports:
- Clk  in  1  system clock, 50 MHz.
- Reset  in  1  synchronous, active-high; clears all state.
- Load  in  1  level; in IDLE, loads SW as dividend into the quotient register and clears the remainder.
- Run  in  1  level pushbutton; a high level sampled in IDLE starts one division.
- SW  in  N  data switches: the dividend on Load, the divisor when the START state samples it.
- Aval  out  N  remainder register (A[N-1:0]); shows intermediate values during a division.
- Bval  out  N  quotient register (Q); holds the dividend before a run and the quotient after it.
- Xval  out  1  divide-by-zero flag for the last run.
- Done  out  1  high while in DONE.

Behaviour:
- Reset (sync, any state, including mid-division):
  - Next edge: state=IDLE, A=0, Q=0, D=0, cnt=0.
  - Outputs: Aval=0, Bval=0, Xval=0, Done=0.
- Internal registers:
  - A: N+1 bits; Aval=A[N-1:0]. The extra bit covers a shifted partial remainder up to 2D-1.
  - Q: N bits.
  - D: N-bit divisor.
  - cnt: counts 0..N-1.
- State IDLE:
  - Load=1 → Q<=SW, A<=0, Xval<=0; stays IDLE.
  - Else Run=1 → START.
  - Load has priority if both are high.
- State START (1 cycle):
  - D<=SW, A<=0, cnt<=0, Xval<=(SW==0).
  - Q is unchanged; it holds the current dividend.
  - Next state: SHIFT.
- State SHIFT:
  - {A,Q} <= {A,Q}<<1; Q[0] temporarily becomes 0.
  - Next state: SUB.
- State SUB:
  - diff = A - {1'b0,D}, computed at N+1 bits.
  - If diff is non-negative (no borrow): A<=diff, Q[0]<=1. Otherwise A and Q are unchanged (Q[0] stays 0).
  - If cnt==N-1 → DONE; else cnt<=cnt+1 → SHIFT.
- State DONE:
  - Done=1; all registers hold.
  - Stays in DONE while Run=1. Run=0 → IDLE.
  - One press performs exactly one division, with no auto-repeat.
- Latency:
  - The edge that samples Run in IDLE enters START.
  - Done is asserted after 2N+2 total edges (18 for N=8).
- Chaining: a new Run with no intervening Load divides the current quotient Q by the new SW.
- Divide by zero:
  - The algorithm still runs normally, with Xval=1.
  - Results: Q = 2^N-1, Aval = the original dividend.
  - No special-case datapath is used.
- Load while not in IDLE: ignored.
- Run held high through Reset: after reset the FSM is in IDLE and starts on the next edge where Run=1.

Decomposition:
- divider_pkg:
  - state enum typedef (IDLE, START, SHIFT, SUB, DONE).
  - default width constant.
- One sub-module: divider_control (FSM + cnt, emitting ld_d, clr_a, shift, sub_en, done).
- The datapath (A/Q/D registers, subtractor) stays in seq_divider.

Test Plan:
- Reset → next edge: Aval=0, Bval=0, Xval=0, Done=0.
- Load with SW=59, then Run with SW=7 → Done after 18 edges; Bval=8, Aval=3, Xval=0. Run held for 5 more cycles → no change.
- Chain: release Run, SW=3, Run → Bval=2, Aval=2.
- Load SW=255, Run SW=1 → Bval=255, Aval=0. Load SW=7, Run SW=59 → Bval=0, Aval=7.
- Load SW=200, Run SW=0 → Xval=1, Bval=255, Aval=200, Done=1.
- Load SW=100, Run SW=9, assert Reset on the 5th cycle after Run → next edge all outputs 0, state IDLE. A Load during SHIFT/SUB is ignored, and the final Bval=11, Aval=1.

Source files
------------

// File: rtl/divider_pkg.sv
`default_nettype none
// ============================================================================
// Module      : divider_pkg
// Description : Shared types and constants for the sequential restoring
//               divider: FSM state encoding and default operand width.
// Revision    : 1.0 - initial release
// ============================================================================
package divider_pkg;

    localparam int DEFAULT_N = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        SHIFT = 3'd2,
        SUB   = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_divider_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider_if
// Description : Front-panel bundle for the divider.
//               Load/Run/SW : panel controls and data switches
//               Aval/Bval   : remainder / quotient registers for display
//               Xval        : divide-by-zero flag, Done : result ready
//               master = panel side, slave = divider side.
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_divider_if import divider_pkg::*; #(
    parameter int N = DEFAULT_N
) ();
    logic         Load;
    logic         Run;
    logic [N-1:0] SW;
    logic [N-1:0] Aval;
    logic [N-1:0] Bval;
    logic         Xval;
    logic         Done;

    modport master (output Load, Run, SW, input Aval, Bval, Xval, Done);
    modport slave  (input Load, Run, SW, output Aval, Bval, Xval, Done);
endinterface
`default_nettype wire

// File: rtl/divider_control.sv
`default_nettype none
// ============================================================================
// Module      : divider_control
// Description : Sequencer for the restoring divider. Walks IDLE -> START ->
//               (SHIFT, SUB) x N -> DONE and emits datapath strobes.
//               Clk/Reset    : clock, sync active-high reset
//               load/run     : panel controls
//               ld_q         : load dividend (IDLE with Load)
//               ld_d/clr_a   : latch divisor, clear remainder (START)
//               shift/sub_en : shift step / trial-subtract step
//               done         : high while in DONE
// Revision    : 1.0 - initial release
// ============================================================================
module divider_control import divider_pkg::*; #(
    parameter int N = DEFAULT_N
) (
    input  logic Clk,
    input  logic Reset,
    input  logic load,
    input  logic run,
    output logic ld_q,
    output logic ld_d,
    output logic clr_a,
    output logic shift,
    output logic sub_en,
    output logic done
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] c_last = CW'(N - 1);

    state_t         r_state, w_state_nxt;
    logic [CW-1:0]  r_cnt,   w_cnt_nxt;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        ld_q        = 1'b0;
        ld_d        = 1'b0;
        clr_a       = 1'b0;
        shift       = 1'b0;
        sub_en      = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                // Load wins over Run so a held Load never starts a division
                if (load)     ld_q = 1'b1;
                else if (run) w_state_nxt = START;
            end
            START: begin
                ld_d        = 1'b1;
                clr_a       = 1'b1;
                w_cnt_nxt   = '0;
                w_state_nxt = SHIFT;
            end
            SHIFT: begin
                shift       = 1'b1;
                w_state_nxt = SUB;
            end
            SUB: begin
                sub_en = 1'b1;
                if (r_cnt == c_last) begin
                    w_state_nxt = DONE;
                end else begin
                    w_cnt_nxt   = r_cnt + CW'(1);
                    w_state_nxt = SHIFT;
                end
            end
            DONE: begin
                done = 1'b1;
                // Wait for release so one press yields exactly one division
                if (!run) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Sequential unsigned restoring divider, N-bit operands.
//               Dividend loaded from SW on Load, divisor sampled from SW on
//               Run; quotient on Bval, remainder on Aval after 2N+2 edges.
//               Clk/Reset : clock, sync active-high reset
//               bus       : seq_divider_if.slave front-panel bundle
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider import divider_pkg::*; #(
    parameter int N = DEFAULT_N
) (
    input  logic           Clk,
    input  logic           Reset,
    seq_divider_if.slave   bus
);
    // A carries one extra bit: after a shift it may hold up to 2D-1
    logic [N:0]   r_a;
    logic [N-1:0] r_q;
    logic [N-1:0] r_d;
    logic         r_x;
    logic [N:0]   w_diff;

    logic w_ld_q, w_ld_d, w_clr_a, w_shift, w_sub_en, w_done;

    divider_control #(.N(N)) u_ctrl (
        .Clk    (Clk),
        .Reset  (Reset),
        .load   (bus.Load),
        .run    (bus.Run),
        .ld_q   (w_ld_q),
        .ld_d   (w_ld_d),
        .clr_a  (w_clr_a),
        .shift  (w_shift),
        .sub_en (w_sub_en),
        .done   (w_done)
    );

    // A < 2D always holds in SUB, so bit N of the wrapped difference is
    // exactly the borrow.
    assign w_diff = r_a - {1'b0, r_d};

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_a <= '0;
            r_q <= '0;
            r_d <= '0;
            r_x <= 1'b0;
        end else begin
            if (w_ld_q) begin
                r_q <= bus.SW;
                r_a <= '0;
                r_x <= 1'b0;
            end
            if (w_ld_d) begin
                r_d <= bus.SW;
                r_x <= (bus.SW == '0);
            end
            if (w_clr_a) begin
                r_a <= '0;
            end
            if (w_shift) begin
                // A[N] is zero here (previous SUB left A < D), so it is dropped
                {r_a, r_q} <= {r_a[N-1:0], r_q, 1'b0};
            end
            if (w_sub_en && !w_diff[N]) begin
                r_a    <= w_diff;
                r_q[0] <= 1'b1;
            end
        end
    end

    assign bus.Aval = r_a[N-1:0];
    assign bus.Bval = r_q;
    assign bus.Xval = r_x;
    assign bus.Done = w_done;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_divider
// Description : Directed self-checking bench for seq_divider (N=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider;
    localparam int N = 8;

    logic Clk;
    logic Reset;
    int   n_assert;
    int   n_fail;

    seq_divider_if #(.N(N)) bus ();

    seq_divider #(.N(N)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input int a, input int b,
                             input int x, input int d);
        check({tag, ".Aval"}, int'(bus.Aval), a);
        check({tag, ".Bval"}, int'(bus.Bval), b);
        check({tag, ".Xval"}, int'(bus.Xval), x);
        check({tag, ".Done"}, int'(bus.Done), d);
    endtask

    task automatic do_load(input int v);
        bus.Load = 1'b1;
        bus.SW   = v[N-1:0];
        tick();
        bus.Load = 1'b0;
    endtask

    // Raise Run with divisor on SW and count edges until Done. Optionally
    // pulse Load with a junk value for two cycles from edge inj (0 = none).
    task automatic do_run(input string tag, input int dv, input int inj);
        int edges;
        edges    = 0;
        bus.Run  = 1'b1;
        bus.SW   = dv[N-1:0];
        while (edges < 100) begin
            tick();
            edges++;
            if (inj != 0 && edges == inj) begin
                bus.Load = 1'b1;
                bus.SW   = 8'd77;
            end
            if (inj != 0 && edges == inj + 2) bus.Load = 1'b0;
            if (bus.Done) break;
        end
        bus.Load = 1'b0;
        check({tag, ".latency"}, edges, 2 * N + 2);
    endtask

    task automatic release_run();
        bus.Run = 1'b0;
        tick();
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        Reset    = 1'b1;
        bus.Load = 1'b1;
        bus.Run  = 1'b0;
        bus.SW   = 8'hAA;
        tick();
        check_out("reset", 0, 0, 0, 0);
        Reset    = 1'b0;
        bus.Load = 1'b0;
        tick();

        // 59 / 7 = 8 r 3
        do_load(59);
        check("load59.Bval", int'(bus.Bval), 59);
        do_run("d59_7", 7, 0);
        check_out("d59_7", 3, 8, 0, 1);
        repeat (5) tick();
        check_out("d59_7_hold", 3, 8, 0, 1);
        release_run();
        check("d59_7_rel.Done", int'(bus.Done), 0);

        // chained: 8 / 3 = 2 r 2
        do_run("chain8_3", 3, 0);
        check_out("chain8_3", 2, 2, 0, 1);
        release_run();

        // 255 / 1 = 255 r 0
        do_load(255);
        do_run("d255_1", 1, 0);
        check_out("d255_1", 0, 255, 0, 1);
        release_run();

        // 7 / 59 = 0 r 7
        do_load(7);
        do_run("d7_59", 59, 0);
        check_out("d7_59", 7, 0, 0, 1);
        release_run();

        // 200 / 0 -> quotient all ones, remainder = dividend, flag set
        do_load(200);
        do_run("d200_0", 0, 0);
        check_out("d200_0", 200, 255, 1, 1);
        release_run();
        do_load(5);
        check("load_clears_x.Xval", int'(bus.Xval), 0);

        // reset in the middle of a division, with Run held through it
        do_load(100);
        bus.Run = 1'b1;
        bus.SW  = 8'd9;
        repeat (5) tick();
        Reset = 1'b1;
        tick();
        check_out("midreset", 0, 0, 0, 0);
        Reset   = 1'b0;
        bus.Run = 1'b0;
        tick();
        check_out("post_reset_idle", 0, 0, 0, 0);

        // 100 / 9 = 11 r 1, with a Load pulse during SHIFT/SUB ignored
        do_load(100);
        do_run("d100_9", 9, 4);
        check_out("d100_9", 1, 11, 0, 1);
        release_run();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
